// File: rtl/regfile_wr_arbiter.sv
// Two-requester register-file write arbiter: round-robin on contention,
// registered write port, address-0 write discard counter and RAW hazard flag.
module regfile_wr_arbiter #(
    parameter int BUS_WIDTH  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [BUS_WIDTH-1:0]  alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BUS_WIDTH-1:0]  mem_data,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [BUS_WIDTH-1:0]  wr_data,
    output logic                  hazard,
    output logic [7:0]            zero_wr_cnt
);

    logic                  prio_q, prio_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [BUS_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [7:0]            zero_wr_cnt_q, zero_wr_cnt_d;

    logic                  xfer;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [BUS_WIDTH-1:0]  win_data;

    // prio only matters when both requesters are valid at once
    always_comb begin
        alu_ready = alu_valid && (!mem_valid || !prio_q);
        mem_ready = mem_valid && (!alu_valid || prio_q);
        xfer      = alu_ready || mem_ready;
        win_addr  = alu_ready ? alu_addr : mem_addr;
        win_data  = alu_ready ? alu_data : mem_data;
    end

    always_comb begin
        prio_d        = prio_q;
        we_d          = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        zero_wr_cnt_d = zero_wr_cnt_q;
        if (alu_ready) begin
            prio_d = 1'b1;
        end else if (mem_ready) begin
            prio_d = 1'b0;
        end
        if (xfer) begin
            if (win_addr != '0) begin
                we_d      = 1'b1;
                wr_addr_d = win_addr;
                wr_data_d = win_data;
            end else if (zero_wr_cnt_q != 8'hFF) begin
                // address 0 is read-only: swallow the write, just count it
                zero_wr_cnt_d = zero_wr_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q        <= 1'b0;
            we_q          <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            zero_wr_cnt_q <= 8'd0;
        end else begin
            prio_q        <= prio_d;
            we_q          <= we_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            zero_wr_cnt_q <= zero_wr_cnt_d;
        end
    end

    always_comb begin
        we          = we_q;
        wr_addr     = wr_addr_q;
        wr_data     = wr_data_q;
        zero_wr_cnt = zero_wr_cnt_q;
        hazard      = we_q && (((rd_addr_a == wr_addr_q) && (rd_addr_a != '0)) ||
                               ((rd_addr_b == wr_addr_q) && (rd_addr_b != '0)));
    end

endmodule
